vga_pixel_sink: RTL and testbench

VGA_PIXEL_SINK -- requirements
Module: vga_pixel_sink

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/framebuffer_ram.sv | 36 +++
 rtl/vga_pixel_sink.sv | 146 ++++++++++++++
 tb/tb_vga_pixel_sink.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module : vga_pkg
// Brief  : VGA timing defaults, packed-colour field positions and frame-buffer
//          geometry shared by the pixel sink and its storage.
// Rev    : 1.0
// ============================================================================
package vga_pkg;

   localparam int DEF_H_VIS  = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;
   localparam int DEF_V_VIS  = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;

   localparam int FB_W     = 160;
   localparam int FB_H     = 120;
   localparam int FB_DEPTH = FB_W * FB_H;
   localparam int FB_AW    = 15;
   localparam int COLOUR_W = 18;
   localparam int CNT_W    = 10;

   localparam int R_MSB = 17;
   localparam int R_LSB = 12;
   localparam int G_MSB = 11;
   localparam int G_LSB = 6;
   localparam int B_MSB = 5;
   localparam int B_LSB = 0;

   // y*160 + x as two shifts and an add, no multiplier
   function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
      logic [FB_AW-1:0] w_y;
      w_y = {8'd0, y};
      return (w_y << 7) + (w_y << 5) + {7'd0, x};
   endfunction

endpackage
`default_nettype wire

// File: rtl/framebuffer_ram.sv
`default_nettype none
// ============================================================================
// Module : framebuffer_ram
// Brief  : Simple dual-port frame store, one write port and one registered
//          read port with read-before-write behaviour on address collision.
// Rev    : 1.0
// ============================================================================
module framebuffer_ram
   import vga_pkg::*;
#(
   parameter int DEPTH  = FB_DEPTH,
   parameter int WIDTH  = COLOUR_W,
   parameter int ADDR_W = FB_AW
) (
   input  logic              clock,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [0:DEPTH-1];

   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         o_rdata <= r_mem[i_raddr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/vga_pixel_sink.sv
`default_nettype none
// ============================================================================
// Module : vga_pixel_sink
// Brief  : 160x120 logical frame buffer scanned out 4x4-replicated as VGA.
// Rev    : 1.0
// ============================================================================
module vga_pixel_sink
   import vga_pkg::*;
#(
   parameter int H_VIS  = DEF_H_VIS,
   parameter int H_FP   = DEF_H_FP,
   parameter int H_SYNC = DEF_H_SYNC,
   parameter int H_BP   = DEF_H_BP,
   parameter int V_VIS  = DEF_V_VIS,
   parameter int V_FP   = DEF_V_FP,
   parameter int V_SYNC = DEF_V_SYNC,
   parameter int V_BP   = DEF_V_BP
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic [7:0]          vga_x,
   input  logic [6:0]          vga_y,
   input  logic [COLOUR_W-1:0] vga_colour,
   input  logic                vga_write,
   output logic [5:0]          vga_r,
   output logic [5:0]          vga_g,
   output logic [5:0]          vga_b,
   output logic                vga_hs,
   output logic                vga_vs,
   output logic                vga_blank_n,
   output logic                frame_start
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] C_H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] C_V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] C_H_VIS      = CNT_W'(H_VIS);
   localparam logic [CNT_W-1:0] C_V_VIS      = CNT_W'(V_VIS);
   localparam logic [CNT_W-1:0] C_V_VIS_LAST = CNT_W'(V_VIS - 1);
   localparam logic [CNT_W-1:0] C_HS_BEG     = CNT_W'(H_VIS + H_FP);
   localparam logic [CNT_W-1:0] C_HS_END     = CNT_W'(H_VIS + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] C_VS_BEG     = CNT_W'(V_VIS + V_FP);
   localparam logic [CNT_W-1:0] C_VS_END     = CNT_W'(V_VIS + V_FP + V_SYNC);

   logic                r_pix_en;
   logic [CNT_W-1:0]    r_hcount;
   logic [CNT_W-1:0]    r_vcount;
   logic                r_hs_d1;
   logic                r_vs_d1;
   logic                r_vis_d1;

   logic                w_h_last;
   logic                w_v_last;
   logic                w_hs_raw;
   logic                w_vs_raw;
   logic                w_vis_raw;
   logic [7:0]          w_rd_x;
   logic [6:0]          w_rd_y;
   logic [FB_AW-1:0]    w_rd_addr;
   logic [FB_AW-1:0]    w_wr_addr;
   logic                w_wr_en;
   logic [COLOUR_W-1:0] w_rd_data;

   assign w_h_last  = (r_hcount == C_H_LAST);
   assign w_v_last  = (r_vcount == C_V_LAST);
   assign w_hs_raw  = !((r_hcount >= C_HS_BEG) && (r_hcount < C_HS_END));
   assign w_vs_raw  = !((r_vcount >= C_VS_BEG) && (r_vcount < C_VS_END));
   assign w_vis_raw = (r_hcount < C_H_VIS) && (r_vcount < C_V_VIS);

   // Blanked positions read address 0 so the index never leaves the array
   assign w_rd_x    = r_hcount[9:2];
   assign w_rd_y    = r_vcount[8:2];
   assign w_rd_addr = w_vis_raw ? fb_addr(w_rd_x, w_rd_y) : '0;

   assign w_wr_addr = fb_addr(vga_x, vga_y);
   assign w_wr_en   = resetn && vga_write && (vga_x < 8'(FB_W)) && (vga_y < 7'(FB_H));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_pix_en <= 1'b0;
         r_hcount <= '0;
         r_vcount <= '0;
      end else begin
         r_pix_en <= ~r_pix_en;
         if (r_pix_en) begin
            if (w_h_last) begin
               r_hcount <= '0;
               r_vcount <= w_v_last ? '0 : r_vcount + 1'b1;
            end else begin
               r_hcount <= r_hcount + 1'b1;
            end
         end
      end
   end

   framebuffer_ram #(
      .DEPTH  (FB_DEPTH),
      .WIDTH  (COLOUR_W),
      .ADDR_W (FB_AW)
   ) u_ram (
      .clock   (clock),
      .i_we    (w_wr_en),
      .i_waddr (w_wr_addr),
      .i_wdata (vga_colour),
      .i_re    (r_pix_en),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd_data)
   );

   // Stage 1 runs beside the RAM read; stage 2 lands colour and sync together
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_hs_d1     <= 1'b1;
         r_vs_d1     <= 1'b1;
         r_vis_d1    <= 1'b0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
      end else if (r_pix_en) begin
         r_hs_d1     <= w_hs_raw;
         r_vs_d1     <= w_vs_raw;
         r_vis_d1    <= w_vis_raw;
         vga_hs      <= r_hs_d1;
         vga_vs      <= r_vs_d1;
         vga_blank_n <= r_vis_d1;
         vga_r       <= r_vis_d1 ? w_rd_data[R_MSB:R_LSB] : '0;
         vga_g       <= r_vis_d1 ? w_rd_data[G_MSB:G_LSB] : '0;
         vga_b       <= r_vis_d1 ? w_rd_data[B_MSB:B_LSB] : '0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= r_pix_en && w_h_last && (r_vcount == C_V_VIS_LAST);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_sink.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_pixel_sink
// Brief  : Directed self-checking bench; scan timing shrunk to a 32x16 visible
//          raster (48x22 total) so whole frames stay short.
// Rev    : 1.0
// ============================================================================
module tb_vga_pixel_sink;

   localparam int LIMIT = 6400;

   localparam logic [17:0] RED  = 18'h3F000;
   localparam logic [17:0] GRN  = 18'h00FC0;
   localparam logic [17:0] V10  = 18'h0A5A5;
   localparam logic [17:0] PRE2 = 18'h15555;
   localparam logic [17:0] OLD  = 18'h2AAAA;
   localparam logic [17:0] NEW  = 18'h1C71C;

   logic        clock;
   logic        resetn;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [17:0] vga_colour;
   logic        vga_write;
   logic [5:0]  vga_r;
   logic [5:0]  vga_g;
   logic [5:0]  vga_b;
   logic        vga_hs;
   logic        vga_vs;
   logic        vga_blank_n;
   logic        frame_start;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int fs_hi = 0;

   logic [17:0] cap [0:15][0:31];
   int          cap_row;
   int          cap_col;
   logic        prev_blank;
   logic        prev_vs;

   vga_pixel_sink #(
      .H_VIS (32), .H_FP (4), .H_SYNC (8), .H_BP (4),
      .V_VIS (16), .V_FP (2), .V_SYNC (2), .V_BP (2)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_write   (vga_write),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_blank_n (vga_blank_n),
      .frame_start (frame_start)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc = cyc + 1;
      if (frame_start) fs_hi = fs_hi + 1;
   end

   // Rebuild the displayed picture from blank_n/vs only (2 clocks per pixel)
   always @(negedge clock) begin
      if (!resetn) begin
         cap_row    = 0;
         cap_col    = 0;
         prev_blank = 1'b0;
         prev_vs    = 1'b1;
      end else begin
         if (prev_vs && !vga_vs) cap_row = 0;
         if (vga_blank_n) begin
            if (cap_row < 16 && cap_col < 64) cap[cap_row][cap_col/2] = {vga_r, vga_g, vga_b};
            cap_col = cap_col + 1;
         end else if (prev_blank) begin
            cap_row = cap_row + 1;
            cap_col = 0;
         end
         prev_blank = vga_blank_n;
         prev_vs    = vga_vs;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return vga_hs;
         1:       return vga_vs;
         2:       return vga_blank_n;
         default: return frame_start;
      endcase
   endfunction

   task automatic wait_edge(input string tag, input int sel, input logic rising, output int t);
      int n;
      n = 0;
      while (sig(sel) !== ~rising && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      while (sig(sel) !== rising && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      chk(tag, {31'd0, (n < LIMIT) && (sig(sel) === rising)}, 32'd1);
      t = cyc;
   endtask

   task automatic wr(input logic [7:0] x, input logic [6:0] y, input logic [17:0] c);
      vga_x      = x;
      vga_y      = y;
      vga_colour = c;
      vga_write  = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      int t1, t2, t3, f1, f2, n0;
      resetn     = 1'b0;
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      vga_write  = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_hs", {31'd0, vga_hs}, 1);
      chk("rst_vs", {31'd0, vga_vs}, 1);
      chk("rst_blank", {31'd0, vga_blank_n}, 0);
      chk("rst_rgb", {14'd0, vga_r, vga_g, vga_b}, 0);
      chk("rst_fs", {31'd0, frame_start}, 0);

      resetn = 1'b1;
      wr(8'd0,   7'd0,   RED);
      wr(8'd1,   7'd0,   V10);
      wr(8'd2,   7'd0,   PRE2);
      wr(8'd2,   7'd1,   OLD);
      wr(8'd7,   7'd3,   GRN);
      wr(8'd159, 7'd119, GRN);
      wr(8'd0,   7'd5,   18'h12345);
      wr(8'd0,   7'd6,   18'h23456);
      wr(8'd95,  7'd1,   18'h34567);
      wr(8'd160, 7'd5,   18'h3FFFF);
      wr(8'd255, 7'd0,   18'h3FFFF);
      vga_write = 1'b0;
      @(negedge clock);
      chk("mem_0",     {14'd0, dut.u_ram.r_mem[0]},     {14'd0, RED});
      chk("mem_1",     {14'd0, dut.u_ram.r_mem[1]},     {14'd0, V10});
      chk("mem_800",   {14'd0, dut.u_ram.r_mem[800]},   32'h12345);
      chk("mem_960",   {14'd0, dut.u_ram.r_mem[960]},   32'h23456);
      chk("mem_255",   {14'd0, dut.u_ram.r_mem[255]},   32'h34567);
      chk("mem_19199", {14'd0, dut.u_ram.r_mem[19199]}, {14'd0, GRN});

      wait_edge("wait_hs1", 0, 1'b0, t1);
      wait_edge("wait_hs2", 0, 1'b1, t2);
      wait_edge("wait_hs3", 0, 1'b0, t3);
      chk("hs_period", t3 - t1, 96);
      chk("hs_low", t2 - t1, 16);
      wait_edge("wait_vs1", 1, 1'b0, t1);
      wait_edge("wait_vs2", 1, 1'b1, t2);
      wait_edge("wait_vs3", 1, 1'b0, t3);
      chk("vs_period", t3 - t1, 2112);
      chk("vs_low", t2 - t1, 192);
      wait_edge("wait_bl1", 2, 1'b1, t1);
      wait_edge("wait_bl2", 2, 1'b0, t2);
      chk("blank_high", t2 - t1, 64);
      wait_edge("wait_fs1", 3, 1'b1, f1);
      n0 = fs_hi;
      @(negedge clock);
      chk("fs_width", {31'd0, frame_start}, 0);
      wait_edge("wait_fs2", 3, 1'b1, f2);
      chk("fs_period", f2 - f1, 2112);
      chk("fs_count", fs_hi - n0, 1);
      wait_edge("wait_vs4", 1, 1'b0, t1);
      chk("fs_to_vs", t1 - f2, 196);

      wait_edge("wait_vs5", 1, 1'b0, t1);
      chk("px_0_0",   {14'd0, cap[0][0]},   {14'd0, RED});
      chk("px_3_3",   {14'd0, cap[3][3]},   {14'd0, RED});
      chk("px_3_0",   {14'd0, cap[0][3]},   {14'd0, RED});
      chk("px_4_0",   {14'd0, cap[0][4]},   {14'd0, V10});
      chk("px_7_3",   {14'd0, cap[3][7]},   {14'd0, V10});
      chk("px_28_12", {14'd0, cap[12][28]}, {14'd0, GRN});
      chk("px_31_15", {14'd0, cap[15][31]}, {14'd0, GRN});
      chk("px_8_0",   {14'd0, cap[0][8]},   {14'd0, PRE2});
      chk("px_8_4",   {14'd0, cap[4][8]},   {14'd0, OLD});

      // Land the write on the final scan read of logical (2,1): physical (11,7)
      repeat (1075) @(negedge clock);
      vga_x      = 8'd2;
      vga_y      = 7'd1;
      vga_colour = NEW;
      vga_write  = 1'b1;
      @(negedge clock);
      vga_write  = 1'b0;
      wait_edge("wait_vs6", 1, 1'b0, t1);
      chk("coll_11_7_old", {14'd0, cap[7][11]}, {14'd0, OLD});
      chk("coll_8_4_old",  {14'd0, cap[4][8]},  {14'd0, OLD});
      wait_edge("wait_vs7", 1, 1'b0, t1);
      chk("coll_11_7_new", {14'd0, cap[7][11]}, {14'd0, NEW});
      chk("coll_8_4_new",  {14'd0, cap[4][8]},  {14'd0, NEW});

      // Output is showing physical (9,6) here, mid-frame and visible
      repeat (978) @(negedge clock);
      chk("pre_rst_blank", {31'd0, vga_blank_n}, 1);
      chk("pre_rst_rgb", {14'd0, vga_r, vga_g, vga_b}, {14'd0, NEW});
      resetn     = 1'b0;
      vga_x      = 8'd2;
      vga_y      = 7'd0;
      vga_colour = 18'h3FFFF;
      vga_write  = 1'b1;
      #1;
      chk("mrst_hs", {31'd0, vga_hs}, 1);
      chk("mrst_vs", {31'd0, vga_vs}, 1);
      chk("mrst_blank", {31'd0, vga_blank_n}, 0);
      chk("mrst_rgb", {14'd0, vga_r, vga_g, vga_b}, 0);
      chk("mrst_fs", {31'd0, frame_start}, 0);
      repeat (3) @(negedge clock);
      resetn    = 1'b1;
      vga_write = 1'b0;
      n0 = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clock);
         n0++;
         @(negedge clock);
         if (!vga_hs) break;
      end
      chk("hs_after_rst", n0, 76);
      chk("mem_2_kept", {14'd0, dut.u_ram.r_mem[2]}, {14'd0, PRE2});
      wait_edge("wait_vs8", 1, 1'b0, t1);
      chk("post_px_0_0",   {14'd0, cap[0][0]},   {14'd0, RED});
      chk("post_px_8_0",   {14'd0, cap[0][8]},   {14'd0, PRE2});
      chk("post_px_8_4",   {14'd0, cap[4][8]},   {14'd0, NEW});
      chk("post_px_31_15", {14'd0, cap[15][31]}, {14'd0, GRN});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
